// File: rtl/utf8_pkg.sv
// Shared types and constants for the streaming UTF-8 decoder.
//   err_e   : error code attached to every decoded entry (0 = clean)
//   state_e : decoder FSM state
//   min_cp  : smallest code point legally encoded with a given sequence length
package utf8_pkg;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_INVALID   = 3'd1,
        ERR_TRUNCATED = 3'd2,
        ERR_OVERLONG  = 3'd3,
        ERR_SURROGATE = 3'd4,
        ERR_RANGE     = 3'd5
    } err_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONT = 1'b1
    } state_e;

    localparam logic [20:0] REPLACEMENT_CP = 21'h00FFFD;
    localparam logic [20:0] MAX_CP         = 21'h10FFFF;
    localparam logic [20:0] SURR_LO        = 21'h00D800;
    localparam logic [20:0] SURR_HI        = 21'h00DFFF;

    // Overlong thresholds for 2-, 3- and 4-byte sequences.
    localparam logic [20:0] MIN_CP2 = 21'h000080;
    localparam logic [20:0] MIN_CP3 = 21'h000800;
    localparam logic [20:0] MIN_CP4 = 21'h010000;

    function automatic logic [20:0] min_cp(input logic [2:0] seq_len);
        case (seq_len)
            3'd2:    return MIN_CP2;
            3'd3:    return MIN_CP3;
            default: return MIN_CP4;
        endcase
    endfunction

endpackage

// File: rtl/utf8_sync_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded entries.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the queue)
//   push, din    : write request / data (ignored when full)
//   full         : no free entry
//   pop          : consume head (ignored when empty)
//   valid, dout  : head present / head data (dout forced to 0 when empty)
module utf8_sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign valid   = !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 to code point decoder with an output queue.
// Handshake: a byte moves when in_valid && in_ready on a rising edge; an entry
// leaves the queue when out_valid && out_ready on a rising edge. in_ready never
// depends on out_ready.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : byte handshake
//   in_byte, in_last          : byte and end-of-stream marker
//   out_valid/out_ready       : entry handshake
//   out_cp, out_err, out_last : decoded code point, error code, stream end
//   err_count                 : saturating count of errored entries pushed
//   busy                      : a partial multi-byte sequence is held
module utf8_stream_decoder
    import utf8_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter bit CHK_RANGE   = 1'b1,
    parameter bit REJECT_SURR = 1'b1,
    parameter bit REPLACE     = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out_cp,
    output logic [2:0]       out_err,
    output logic             out_last,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    state_e      state, nxt_state;
    logic [20:0] acc, nxt_acc, acc_next;
    logic [1:0]  need, nxt_need;
    logic [2:0]  seq_len, nxt_len;

    logic        is_cont, stall, accept, fifo_full;
    logic        push, push_last;
    logic [20:0] push_raw, push_cp;
    err_e        push_err;
    logic [24:0] fifo_dout;

    function automatic err_e check_value(input logic [20:0] value, input logic [2:0] len);
        if (value < min_cp(len))                              return ERR_OVERLONG;
        if (CHK_RANGE && value > MAX_CP)                      return ERR_RANGE;
        if (REJECT_SURR && value >= SURR_LO && value <= SURR_HI) return ERR_SURROGATE;
        return ERR_NONE;
    endfunction

    assign is_cont  = (in_byte[7:6] == 2'b10);
    // A non-continuation byte mid-sequence is held back and re-read as a lead byte.
    assign stall    = (state == ST_CONT) && in_valid && !is_cont;
    assign in_ready = !fifo_full && !stall;
    assign accept   = in_valid && in_ready;
    assign acc_next = {acc[14:0], in_byte[5:0]};
    assign busy     = (state == ST_CONT);

    always_comb begin
        push      = 1'b0;
        push_raw  = '0;
        push_err  = ERR_NONE;
        push_last = 1'b0;
        nxt_state = state;
        nxt_acc   = acc;
        nxt_need  = need;
        nxt_len   = seq_len;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_acc  = '0;
                    nxt_need = 2'd0;
                    if (!in_byte[7]) begin
                        push      = 1'b1;
                        push_raw  = {13'b0, in_byte};
                        push_last = in_last;
                    end else if (in_byte[7:5] == 3'b110) begin
                        nxt_acc  = {16'b0, in_byte[4:0]};
                        nxt_need = 2'd1;
                        nxt_len  = 3'd2;
                    end else if (in_byte[7:4] == 4'b1110) begin
                        nxt_acc  = {17'b0, in_byte[3:0]};
                        nxt_need = 2'd2;
                        nxt_len  = 3'd3;
                    end else if (in_byte[7:3] == 5'b11110) begin
                        nxt_acc  = {18'b0, in_byte[2:0]};
                        nxt_need = 2'd3;
                        nxt_len  = 3'd4;
                    end else begin
                        push      = 1'b1;
                        push_raw  = {13'b0, in_byte};
                        push_err  = ERR_INVALID;
                        push_last = in_last;
                    end
                    if (nxt_need != 2'd0) begin
                        if (in_last) begin
                            push      = 1'b1;
                            push_raw  = nxt_acc;
                            push_err  = ERR_TRUNCATED;
                            push_last = 1'b1;
                            nxt_need  = 2'd0;
                        end else begin
                            nxt_state = ST_CONT;
                        end
                    end
                end
            end
            ST_CONT: begin
                if (stall) begin
                    // With the queue full the truncation waits; the byte stays held.
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_raw  = acc;
                        push_err  = ERR_TRUNCATED;
                        nxt_need  = 2'd0;
                        nxt_state = ST_IDLE;
                    end
                end else if (accept) begin
                    nxt_acc = acc_next;
                    if (need == 2'd1) begin
                        push      = 1'b1;
                        push_raw  = acc_next;
                        push_err  = check_value(acc_next, seq_len);
                        push_last = in_last;
                        nxt_need  = 2'd0;
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_need = need - 2'd1;
                        if (in_last) begin
                            push      = 1'b1;
                            push_raw  = acc_next;
                            push_err  = ERR_TRUNCATED;
                            push_last = 1'b1;
                            nxt_need  = 2'd0;
                            nxt_state = ST_IDLE;
                        end
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    assign push_cp = (REPLACE && push_err != ERR_NONE) ? REPLACEMENT_CP : push_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            need      <= '0;
            seq_len   <= '0;
            err_count <= '0;
        end else begin
            state   <= nxt_state;
            acc     <= nxt_acc;
            need    <= nxt_need;
            seq_len <= nxt_len;
            if (push && push_err != ERR_NONE && err_count != {CNT_W{1'b1}})
                err_count <= err_count + CNT_W'(1);
        end
    end

    utf8_sync_fifo #(
        .WIDTH (25),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({push_cp, push_err, push_last}),
        .full  (fifo_full),
        .pop   (out_ready),
        .valid (out_valid),
        .dout  (fifo_dout)
    );

    assign out_cp   = fifo_dout[24:4];
    assign out_err  = fifo_dout[3:1];
    assign out_last = fifo_dout[0];

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Bench for utf8_stream_decoder: default instance plus a raw-value instance
// (REJECT_SURR=0, REPLACE=0). Entries are {cp, err, last}.
module tb_utf8_stream_decoder;
    import utf8_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready, out_valid, out_last, busy;
    logic [20:0] out_cp;
    logic [2:0]  out_err;
    logic [7:0]  err_count;

    logic        in_valid_b = 1'b0, in_last_b = 1'b0, out_ready_b = 1'b1;
    logic [7:0]  in_byte_b = 8'h00;
    logic        in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [20:0] out_cp_b;
    logic [2:0]  out_err_b;
    logic [7:0]  err_count_b;

    int checks   = 0;
    int failures = 0;

    logic [24:0] exp_q[$];
    logic [24:0] exp_q_b[$];
    logic [24:0] mon_got, mon_exp, mon_got_b, mon_exp_b;
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    utf8_stream_decoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_cp(out_cp), .out_err(out_err),
        .out_last(out_last), .err_count(err_count), .busy(busy)
    );

    utf8_stream_decoder #(
        .FIFO_DEPTH(4), .CHK_RANGE(1'b1), .REJECT_SURR(1'b0), .REPLACE(1'b0), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_byte(in_byte_b), .in_last(in_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_cp(out_cp_b), .out_err(out_err_b),
        .out_last(out_last_b), .err_count(err_count_b), .busy(busy_b)
    );

    function automatic logic [24:0] mk(input logic [20:0] cp, input logic [2:0] e, input logic l);
        return {cp, e, l};
    endfunction

    // Scoreboards: compare every popped entry against the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = {out_cp, out_err, out_last};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_a unexpected entry cp=%h err=%0d last=%0b", out_cp, out_err, out_last);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_a got cp=%h err=%0d last=%0b expected cp=%h err=%0d last=%0b",
                             mon_got[24:4], mon_got[3:1], mon_got[0], mon_exp[24:4], mon_exp[3:1], mon_exp[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            mon_got_b = {out_cp_b, out_err_b, out_last_b};
            checks++;
            if (exp_q_b.size() == 0) begin
                failures++;
                $display("FAIL sb_b unexpected entry cp=%h err=%0d last=%0b", out_cp_b, out_err_b, out_last_b);
            end else begin
                mon_exp_b = exp_q_b.pop_front();
                if (mon_got_b !== mon_exp_b) begin
                    failures++;
                    $display("FAIL sb_b got cp=%h err=%0d last=%0b expected cp=%h err=%0d last=%0b",
                             mon_got_b[24:4], mon_got_b[3:1], mon_got_b[0], mon_exp_b[24:4], mon_exp_b[3:1], mon_exp_b[0]);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Drivers
    task automatic send_byte(input logic [7:0] b, input logic l);
        bit done;
        int n;
        in_valid = 1'b1; in_byte = b; in_last = l;
        done = 1'b0; n = 0;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                checks++; failures++;
                $display("FAIL send_timeout byte=%h in_ready=%0b required 1", b, in_ready);
                done = 1'b1;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_byte_b(input logic [7:0] b, input logic l);
        bit done;
        int n;
        in_valid_b = 1'b1; in_byte_b = b; in_last_b = l;
        done = 1'b0; n = 0;
        while (!done) begin
            @(negedge clk);
            done = in_ready_b;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                checks++; failures++;
                $display("FAIL send_timeout_b byte=%h in_ready=%0b required 1", b, in_ready_b);
                done = 1'b1;
            end
        end
        in_valid_b = 1'b0; in_last_b = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_q_b.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || exp_q_b.size() != 0) begin
            failures++;
            $display("FAIL %s drain pending=%0d/%0d required 0/0", name, exp_q.size(), exp_q_b.size());
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_cp, out_err, out_last, busy} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%0b cp=%h err=%0d last=%0b busy=%0b required all 0",
                     out_valid, out_cp, out_err, out_last, busy);
        end
        checks++;
        if (err_count !== 8'd0) begin
            failures++; $display("FAIL reset_err_count got %0d required 0", err_count);
        end
        checks++;
        if (in_ready !== 1'b1 || in_ready_b !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got %0b/%0b required 1/1", in_ready, in_ready_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        exp_q.push_back(mk(21'h41, 3'd0, 1'b0));
        exp_q.push_back(mk(21'h20AC, 3'd0, 1'b0));
        send_byte(8'h41, 1'b0);
        send_byte(8'hE2, 1'b0);
        send_byte(8'h82, 1'b0);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_mid busy=%0b out_valid=%0b required 1/0", busy, out_valid);
        end
        send_byte(8'hAC, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_cp !== 21'h20AC) begin
            failures++; $display("FAIL basic_latency out_valid=%0b cp=%h required 1/020ac", out_valid, out_cp);
        end
        wait_drain("basic");
    endtask

    task automatic test_overlong();
        exp_q.push_back(mk(21'hFFFD, 3'd3, 1'b0));
        exp_q.push_back(mk(21'hFFFD, 3'd3, 1'b0));
        send_byte(8'hC0, 1'b0); send_byte(8'h80, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'h80, 1'b0); send_byte(8'h80, 1'b0);
        wait_drain("overlong");
        checks++;
        if (err_count !== 8'd2) begin
            failures++; $display("FAIL overlong_err_count got %0d required 2", err_count);
        end
    endtask

    task automatic test_truncated();
        exp_q.push_back(mk(21'hFFFD, 3'd2, 1'b0));
        exp_q.push_back(mk(21'h41, 3'd0, 1'b0));
        send_byte(8'hE2, 1'b0);
        in_valid = 1'b1; in_byte = 8'h41; in_last = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL trunc_stall in_ready=%0b required 0", in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL trunc_release in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("truncated");
        checks++;
        if (err_count !== 8'd3) begin
            failures++; $display("FAIL trunc_err_count got %0d required 3", err_count);
        end
    endtask

    task automatic test_surrogate_range();
        exp_q.push_back(mk(21'hFFFD, 3'd4, 1'b0));
        exp_q.push_back(mk(21'hFFFD, 3'd5, 1'b0));
        send_byte(8'hED, 1'b0); send_byte(8'hA0, 1'b0); send_byte(8'h80, 1'b0);
        send_byte(8'hF4, 1'b0); send_byte(8'h90, 1'b0); send_byte(8'h80, 1'b0); send_byte(8'h80, 1'b0);
        wait_drain("surr_range");
        checks++;
        if (err_count !== 8'd5) begin
            failures++; $display("FAIL surr_range_err_count got %0d required 5", err_count);
        end
    endtask

    task automatic test_invalid_last();
        exp_q.push_back(mk(21'hFFFD, 3'd1, 1'b0));
        exp_q.push_back(mk(21'hFFFD, 3'd1, 1'b0));
        exp_q.push_back(mk(21'hFFFD, 3'd2, 1'b1));
        exp_q.push_back(mk(21'h5A, 3'd0, 1'b1));
        send_byte(8'h80, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hE2, 1'b0); send_byte(8'h82, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL last_trunc_busy got %0b required 0", busy);
        end
        send_byte(8'h5A, 1'b1);
        wait_drain("invalid_last");
        checks++;
        if (err_count !== 8'd8) begin
            failures++; $display("FAIL invalid_last_err_count got %0d required 8", err_count);
        end
    endtask

    task automatic test_raw_values();
        exp_q_b.push_back(mk(21'hD800, 3'd0, 1'b0));
        exp_q_b.push_back(mk(21'h80, 3'd1, 1'b0));
        exp_q_b.push_back(mk(21'h2, 3'd2, 1'b0));
        exp_q_b.push_back(mk(21'h41, 3'd0, 1'b0));
        exp_q_b.push_back(mk(21'h0, 3'd3, 1'b0));
        exp_q_b.push_back(mk(21'h110000, 3'd5, 1'b1));
        send_byte_b(8'hED, 1'b0); send_byte_b(8'hA0, 1'b0); send_byte_b(8'h80, 1'b0);
        send_byte_b(8'h80, 1'b0);
        send_byte_b(8'hE2, 1'b0); send_byte_b(8'h41, 1'b0);
        send_byte_b(8'hC0, 1'b0); send_byte_b(8'h80, 1'b0);
        send_byte_b(8'hF4, 1'b0); send_byte_b(8'h90, 1'b0); send_byte_b(8'h80, 1'b0); send_byte_b(8'h80, 1'b1);
        wait_drain("raw_values");
        checks++;
        if (err_count_b !== 8'd4) begin
            failures++; $display("FAIL raw_err_count got %0d required 4", err_count_b);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(21'(8'h61 + i), 3'd0, 1'b0));
        for (int i = 0; i < 4; i++) send_byte(8'(8'h61 + i), 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_cp !== 21'h61) begin
            failures++;
            $display("FAIL bp_full in_ready=%0b out_valid=%0b cp=%h required 0/1/000061", in_ready, out_valid, out_cp);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_byte = 8'h65;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_pop_same_cycle in_ready=%0b required 0", in_ready);
        end
        send_byte(8'h65, 1'b0);
        wait_drain("backpressure");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hE2, 1'b0); send_byte(8'h82, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_busy_before got %0b required 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_after busy=%0b out_valid=%0b err_count=%0d required 0/0/0", busy, out_valid, err_count);
        end
        exp_q.push_back(mk(21'h41, 3'd0, 1'b0));
        send_byte(8'h41, 1'b0);
        wait_drain("reset_mid");
        checks++;
        if (err_count !== 8'd0) begin
            failures++; $display("FAIL rst_mid_err_count got %0d required 0", err_count);
        end
    endtask

    task automatic test_random();
        logic [20:0] cp;
        logic        l;
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: cp = 21'($urandom_range(0, 'h7F));
                1: cp = 21'($urandom_range('h80, 'h7FF));
                2: cp = ($urandom_range(0, 1) != 0) ? 21'($urandom_range('h800, 'hD7FF))
                                                     : 21'($urandom_range('hE000, 'hFFFF));
                default: cp = 21'($urandom_range('h10000, 'h10FFFF));
            endcase
            l = ($urandom_range(0, 7) == 0);
            exp_q.push_back(mk(cp, 3'd0, l));
            if (cp < 21'h80) begin
                send_byte({1'b0, cp[6:0]}, l);
            end else if (cp < 21'h800) begin
                send_byte({3'b110, cp[10:6]}, 1'b0);
                send_byte({2'b10, cp[5:0]}, l);
            end else if (cp < 21'h10000) begin
                send_byte({4'b1110, cp[15:12]}, 1'b0);
                send_byte({2'b10, cp[11:6]}, 1'b0);
                send_byte({2'b10, cp[5:0]}, l);
            end else begin
                send_byte({5'b11110, cp[20:18]}, 1'b0);
                send_byte({2'b10, cp[17:12]}, 1'b0);
                send_byte({2'b10, cp[11:6]}, 1'b0);
                send_byte({2'b10, cp[5:0]}, l);
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_drain("random");
        checks++;
        if (err_count !== 8'd0) begin
            failures++; $display("FAIL random_err_count got %0d required 0", err_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_overlong();
        test_truncated();
        test_surrogate_range();
        test_invalid_last();
        test_raw_values();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
